// File: rtl/dmem_port_arbiter_if.sv
// Shared data-memory port bundle: core and loader request sides plus the memory side.
// The arbiter takes the slave view; the surrounding core/loader/memory take master.
interface dmem_port_arbiter_if #(
  parameter int BITS_ADDR = 8
);
  logic                 c_req;
  logic                 c_we;
  logic [BITS_ADDR-3:0] c_addr;
  logic [31:0]          c_wdata;
  logic                 c_gnt;
  logic                 core_stall;

  logic                 l_req;
  logic                 l_we;
  logic [BITS_ADDR-3:0] l_addr;
  logic [31:0]          l_wdata;
  logic                 l_gnt;

  logic [31:0]          rdata;
  logic                 mem_we;
  logic [BITS_ADDR-3:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  l_req, l_we, l_addr, l_wdata,
    input  mem_rdata,
    output c_gnt, core_stall, l_gnt, rdata,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output l_req, l_we, l_addr, l_wdata,
    output mem_rdata,
    input  c_gnt, core_stall, l_gnt, rdata,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin, burst-capped arbiter of the data-memory port between core and loader.
// Grant one cycle after request, registered; the loser is held off (core via core_stall).
module dmem_port_arbiter #(
  parameter int BITS_ADDR = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  dmem_port_arbiter_if.slave   bus
);
  localparam int          AW       = BITS_ADDR - 2;
  localparam logic [3:0]  CNT_LAST = 4'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_C = 2'd1,
    OWN_L = 2'd2
  } st_t;

  st_t        st, st_nxt;
  logic       last, last_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic       own_req, oth_req;
  st_t        peer_st;

  logic          sel_req;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;

  always_ff @(posedge CLK) begin
    if (RST) begin
      st   <= IDLE;
      last <= 1'b1;
      cnt  <= 4'd0;
    end else begin
      st   <= st_nxt;
      last <= last_nxt;
      cnt  <= cnt_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    last_nxt = last;
    cnt_nxt  = cnt;
    own_req  = 1'b0;
    oth_req  = 1'b0;
    peer_st  = IDLE;
    case (st)
      IDLE: begin
        cnt_nxt = 4'd0;
        if (bus.c_req && bus.l_req) st_nxt = last ? OWN_C : OWN_L;
        else if (bus.c_req)         st_nxt = OWN_C;
        else if (bus.l_req)         st_nxt = OWN_L;
      end
      OWN_C, OWN_L: begin
        own_req = (st == OWN_C) ? bus.c_req : bus.l_req;
        oth_req = (st == OWN_C) ? bus.l_req : bus.c_req;
        peer_st = (st == OWN_C) ? OWN_L : OWN_C;
        if (!own_req) begin
          st_nxt   = oth_req ? peer_st : IDLE;
          last_nxt = (st == OWN_L);
          cnt_nxt  = 4'd0;
        end else if (oth_req) begin
          // Cap only counts transfers made while the other side is waiting.
          if (cnt >= CNT_LAST) begin
            st_nxt   = peer_st;
            last_nxt = (st == OWN_L);
            cnt_nxt  = 4'd0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end else begin
          cnt_nxt = 4'd0;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_req   = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (st)
      OWN_C: begin
        sel_req   = bus.c_req;
        sel_we    = bus.c_we;
        sel_addr  = bus.c_addr;
        sel_wdata = bus.c_wdata;
      end
      OWN_L: begin
        sel_req   = bus.l_req;
        sel_we    = bus.l_we;
        sel_addr  = bus.l_addr;
        sel_wdata = bus.l_wdata;
      end
      default: ;
    endcase
  end

  assign bus.c_gnt      = (st == OWN_C);
  assign bus.l_gnt      = (st == OWN_L);
  assign bus.core_stall = bus.c_req & ~bus.c_gnt;
  // Reset gates the strobe so a write caught by reset never reaches memory.
  assign bus.mem_we     = sel_we & sel_req & ~RST;
  assign bus.mem_addr   = sel_addr;
  assign bus.mem_wdata  = sel_wdata;
  assign bus.rdata      = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, hand sequences, then random traffic
// against a transfer-level reference model with a shadow memory.
module tb_dmem_port_arbiter;
  localparam int MAXB = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic CLK;
  logic RST;
  logic mem_clr;
  logic [31:0] mem [0:63];

  int n_cmp = 0;
  int n_bad = 0;

  dmem_port_arbiter_if #(.BITS_ADDR(8)) bus ();

  dmem_port_arbiter #(.BITS_ADDR(8), .MAX_BURST(MAXB)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  typedef struct {
    logic        rst, c_req, c_we;
    logic [5:0]  c_addr;
    logic [31:0] c_wdata;
    logic        l_req, l_we;
    logic [5:0]  l_addr;
    logic [31:0] l_wdata;
    logic        e_cg, e_lg, e_we;
    logic [5:0]  e_addr;
    logic        e_stall;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic cr, logic cw, logic [5:0] ca, logic [31:0] cd,
                              logic lr, logic lw, logic [5:0] la, logic [31:0] ld,
                              logic ecg, logic elg, logic ewe, logic [5:0] ea, logic est);
    vec_t v;
    v.rst = rst; v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.l_req = lr; v.l_we = lw; v.l_addr = la; v.l_wdata = ld;
    v.e_cg = ecg; v.e_lg = elg; v.e_we = ewe; v.e_addr = ea; v.e_stall = est;
    v.chk_rd = 1'b0; v.e_rd = 32'd0;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic cr, input logic cw, input logic [5:0] ca,
                       input logic [31:0] cd, input logic lr, input logic lw,
                       input logic [5:0] la, input logic [31:0] ld);
    RST = rst; bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    bus.l_req = lr; bus.l_we = lw; bus.l_addr = la; bus.l_wdata = ld;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: who owns the port, who went last, and how many transfers
  // the current owner has made while the other side was waiting.
  int          own;
  bit          lst;
  int          run;
  logic [31:0] ref_mem [0:63];

  task automatic model_step(input bit rst, input bit cr, input bit lr);
    bit mine, theirs;
    int peer;
    if (rst) begin
      own = 0; lst = 1'b1; run = 0;
      return;
    end
    if (own == 0) begin
      run = 0;
      if (cr && lr) own = lst ? 1 : 2;
      else if (cr)  own = 1;
      else if (lr)  own = 2;
    end else begin
      mine   = (own == 1) ? cr : lr;
      theirs = (own == 1) ? lr : cr;
      peer   = 3 - own;
      if (!mine) begin
        lst = (own == 2);
        own = theirs ? peer : 0;
        run = 0;
      end else if (theirs) begin
        run++;
        if (run == MAXB) begin
          lst = (own == 2);
          own = peer;
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  initial begin
    mem_clr = 1'b1;
    drive(H, L, L, 6'd0, 32'd0, L, L, 6'd0, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    mem_clr = 1'b0;

    // ---------------- directed vector table ----------------
    vt.push_back(mk(H, H, L, 6'd0, 32'd0,          L, L, 6'd0, 32'd0,  L, L, L, 6'd0, H));
    vt.push_back(mk(L, H, H, 6'd5, 32'hDEADBEEF,   L, L, 6'd0, 32'd0,  L, L, L, 6'd0, H));
    vt.push_back(mk(L, H, H, 6'd5, 32'hDEADBEEF,   L, L, 6'd0, 32'd0,  H, L, H, 6'd5, L));
    vt.push_back(mk(L, L, L, 6'd5, 32'd0,          L, L, 6'd0, 32'd0,  H, L, L, 6'd5, L));
    vt.push_back(mk(L, H, L, 6'd5, 32'd0,          L, L, 6'd0, 32'd0,  L, L, L, 6'd0, H));
    begin
      vec_t v;
      v = mk(L, H, L, 6'd5, 32'd0, L, L, 6'd0, 32'd0, H, L, L, 6'd5, L);
      v.chk_rd = 1'b1;
      v.e_rd   = 32'hDEADBEEF;
      vt.push_back(v);
    end
    vt.push_back(mk(L, L, L, 6'd5, 32'd0,          L, L, 6'd0, 32'd0,  H, L, L, 6'd5, L));
    vt.push_back(mk(H, L, L, 6'd0, 32'd0,          L, L, 6'd0, 32'd0,  L, L, L, 6'd0, L));
    vt.push_back(mk(L, H, H, 6'd16, 32'h100,       H, H, 6'd32, 32'h200, L, L, L, 6'd0, H));
    for (int k = 0; k < 4; k++)
      vt.push_back(mk(L, H, H, 6'd16, 32'h100, H, H, 6'd32, 32'h200, H, L, H, 6'd16, L));
    for (int k = 0; k < 4; k++)
      vt.push_back(mk(L, H, H, 6'd16, 32'h100, H, H, 6'd32, 32'h200, L, H, H, 6'd32, H));
    for (int k = 0; k < 4; k++)
      vt.push_back(mk(L, H, H, 6'd16, 32'h100, H, H, 6'd32, 32'h200, H, L, H, 6'd16, L));
    vt.push_back(mk(L, L, L, 6'd16, 32'd0,         L, L, 6'd32, 32'd0, L, H, L, 6'd32, L));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].c_req, vt[i].c_we, vt[i].c_addr, vt[i].c_wdata,
            vt[i].l_req, vt[i].l_we, vt[i].l_addr, vt[i].l_wdata);
      @(negedge CLK);
      chk("vec_c_gnt", i, 32'(bus.c_gnt), 32'(vt[i].e_cg));
      chk("vec_l_gnt", i, 32'(bus.l_gnt), 32'(vt[i].e_lg));
      chk("vec_mem_we", i, 32'(bus.mem_we), 32'(vt[i].e_we));
      chk("vec_mem_addr", i, 32'(bus.mem_addr), 32'(vt[i].e_addr));
      chk("vec_stall", i, 32'(bus.core_stall), 32'(vt[i].e_stall));
      if (vt[i].chk_rd) chk("vec_rdata", i, bus.rdata, vt[i].e_rd);
      next_cycle();
    end

    // ---------------- loader streams 10 words, no contention ----------------
    drive(L, L, L, 6'd0, 32'd0, H, H, 6'd0, 32'hA0);
    @(negedge CLK);
    chk("ldr_req_idle_gnt", 0, 32'(bus.l_gnt), 32'd0);
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      drive(L, L, L, 6'd0, 32'd0, H, H, 6'(i), 32'hA0 + 32'(i));
      @(negedge CLK);
      chk("ldr_stream_gnt", i, 32'(bus.l_gnt), 32'd1);
      chk("ldr_stream_we", i, 32'(bus.mem_we), 32'd1);
      chk("ldr_stream_addr", i, 32'(bus.mem_addr), 32'(i));
      next_cycle();
    end
    drive(L, L, L, 6'd0, 32'd0, L, L, 6'd0, 32'd0);
    @(negedge CLK);
    for (int i = 0; i < 10; i++) chk("ldr_stream_mem", i, mem[i], 32'hA0 + 32'(i));
    next_cycle();

    // ---------------- core release hands over to loader, reset mid-burst ----------------
    drive(L, H, H, 6'd20, 32'h55, L, L, 6'd0, 32'd0);
    @(negedge CLK);
    chk("hand_idle_stall", 0, 32'(bus.core_stall), 32'd1);
    next_cycle();
    @(negedge CLK);
    chk("hand_core_gnt", 0, 32'(bus.c_gnt), 32'd1);
    next_cycle();
    drive(L, L, H, 6'd20, 32'h66, H, H, 6'd30, 32'h77);
    @(negedge CLK);
    chk("hand_drop_c_gnt", 0, 32'(bus.c_gnt), 32'd1);
    chk("hand_drop_we", 0, 32'(bus.mem_we), 32'd0);
    chk("hand_drop_l_gnt", 0, 32'(bus.l_gnt), 32'd0);
    next_cycle();
    @(negedge CLK);
    chk("hand_new_l_gnt", 0, 32'(bus.l_gnt), 32'd1);
    chk("hand_new_we", 0, 32'(bus.mem_we), 32'd1);
    chk("hand_new_addr", 0, 32'(bus.mem_addr), 32'd30);
    next_cycle();
    drive(H, L, L, 6'd0, 32'd0, H, H, 6'd31, 32'h99);
    @(negedge CLK);
    chk("rst_burst_we", 0, 32'(bus.mem_we), 32'd0);
    next_cycle();
    drive(L, L, L, 6'd0, 32'd0, L, L, 6'd31, 32'h99);
    @(negedge CLK);
    chk("rst_after_c_gnt", 0, 32'(bus.c_gnt), 32'd0);
    chk("rst_after_l_gnt", 0, 32'(bus.l_gnt), 32'd0);
    chk("rst_after_addr", 0, 32'(bus.mem_addr), 32'd0);
    chk("rst_mem20", 0, mem[20], 32'h55);
    chk("rst_mem30", 0, mem[30], 32'h77);
    chk("rst_mem31", 0, mem[31], 32'd0);
    next_cycle();

    // ---------------- loader writes 0x13 at 3, core loads it back ----------------
    drive(L, L, L, 6'd0, 32'd0, H, H, 6'd3, 32'h13);
    next_cycle();
    next_cycle();
    drive(L, H, L, 6'd3, 32'd0, L, L, 6'd3, 32'd0);
    @(negedge CLK);
    chk("load_release_l_gnt", 0, 32'(bus.l_gnt), 32'd1);
    next_cycle();
    @(negedge CLK);
    chk("load_c_gnt", 0, 32'(bus.c_gnt), 32'd1);
    chk("load_rdata", 0, bus.rdata, 32'h13);
    chk("load_stall", 0, 32'(bus.core_stall), 32'd0);
    chk("load_we", 0, 32'(bus.mem_we), 32'd0);
    next_cycle();

    // ---------------- random traffic vs reference model ----------------
    drive(H, L, L, 6'd0, 32'd0, L, L, 6'd0, 32'd0);
    mem_clr = 1'b1;
    next_cycle();
    mem_clr = 1'b0;
    own = 0; lst = 1'b1; run = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit          e_cg, e_lg, e_we, req_o, we_o;
      logic [5:0]  addr_o;
      logic [31:0] wd_o;
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            6'($urandom_range(0, 63)), $urandom,
            ($urandom_range(0, 3) != 0), 1'($urandom),
            6'($urandom_range(0, 63)), $urandom);
      @(negedge CLK);
      e_cg   = (own == 1);
      e_lg   = (own == 2);
      req_o  = e_cg ? bus.c_req   : (e_lg ? bus.l_req   : 1'b0);
      we_o   = e_cg ? bus.c_we    : (e_lg ? bus.l_we    : 1'b0);
      addr_o = e_cg ? bus.c_addr  : (e_lg ? bus.l_addr  : 6'd0);
      wd_o   = e_cg ? bus.c_wdata : (e_lg ? bus.l_wdata : 32'd0);
      e_we   = req_o && we_o && !RST;
      chk("rnd_c_gnt", cyc, 32'(bus.c_gnt), 32'(e_cg));
      chk("rnd_l_gnt", cyc, 32'(bus.l_gnt), 32'(e_lg));
      chk("rnd_stall", cyc, 32'(bus.core_stall), 32'(bus.c_req && !e_cg));
      chk("rnd_mem_we", cyc, 32'(bus.mem_we), 32'(e_we));
      chk("rnd_mem_addr", cyc, 32'(bus.mem_addr), 32'(addr_o));
      chk("rnd_mem_wdata", cyc, bus.mem_wdata, wd_o);
      if (req_o && !we_o) chk("rnd_rdata", cyc, bus.rdata, ref_mem[addr_o]);
      if (e_we) ref_mem[addr_o] = wd_o;
      model_step(RST, bus.c_req, bus.l_req);
      next_cycle();
    end

    drive(L, L, L, 6'd0, 32'd0, L, L, 6'd0, 32'd0);
    @(negedge CLK);
    for (int i = 0; i < 64; i++) chk("rnd_final_mem", i, mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter that shares the single data-memory port between the RISC-V core's load/store path and an external program/data loader. The arbiter sits between the ALU-derived word address and store data on one side, and the data memory on the other. It holds the core with a stall output while the loader owns the port. Arbitration is round-robin with a burst cap, so neither requester can starve the other.

## Interface
- BITS_ADDR, 8: byte-address width; memory word address is BITS_ADDR-2 bits
- MAX_BURST, 4: max consecutive transfers by one owner while the other requests (1..15)
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- c_req  in  1  core requests port this cycle (load or store)
- c_we  in  1  core write enable
- c_addr  in  BITS_ADDR-2  core word address
- c_wdata  in  32  core store data
- c_gnt  out  1  core owns port; transfer happens when c_req & c_gnt
- core_stall  out  1  c_req & ~c_gnt; holds PC and register write
- l_req, l_we, l_addr, l_wdata  in  1/1/BITS_ADDR-2/32  loader request, same meaning
- l_gnt  out  1  loader owns port
- rdata  out  32  mem_rdata passed through; valid for the granted requester only
- mem_we  out  1  to memory WE
- mem_addr  out  BITS_ADDR-2  to memory address
- mem_wdata  out  32  to memory write data
- mem_rdata  in  32  combinational read data from memory

## Operation
- State register `st` has three states: IDLE, OWN_C, OWN_L. Other registers: `last` (last owner, 0=core, 1=loader) and `cnt` (4-bit burst count).
- c_gnt = (st==OWN_C); l_gnt = (st==OWN_L). Grants depend only on state.
- Port mux:
  - OWN_C: mem_addr=c_addr, mem_wdata=c_wdata, mem_we=c_we & c_req & ~RST.
  - OWN_L: the same, using the loader inputs.
  - IDLE: mem_addr=0, mem_wdata=0, mem_we=0.
- IDLE transitions:
  - Only c_req: go to OWN_C.
  - Only l_req: go to OWN_L.
  - Both: grant the requester that is not `last`.
  - Neither: stay in IDLE.
  - On entering an OWN state, cnt=0.
- OWN_x (owner x, other y), one transfer per cycle with req_x high:
  - req_x low: go to OWN_y if req_y, else IDLE. Set last=x.
  - req_x high and req_y high and cnt==MAX_BURST-1: this is the final transfer. Go to OWN_y with cnt=0, last=x.
  - req_x high and req_y high, cnt below the limit: stay, cnt+1.
  - req_x high and req_y low: stay, cnt=0. The burst cap applies only under contention.
- Width rules:
  - cnt saturates logic-wise at MAX_BURST-1 and never wraps.
  - Addresses pass through unmodified; no range check.
- Reset: st=IDLE, cnt=0, last=1 (the core wins the first tie).
- Outputs during and after reset:
  - After the reset edge: c_gnt=0, l_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - core_stall = c_req.
- Reset mid-burst:
  - The write in the RST-high cycle is suppressed (mem_we gated).
  - The next cycle is IDLE.
  - Any in-flight transfer is lost; the requester must re-request.
- Simultaneous release and new request:
  - The handover happens with no IDLE bubble.
  - The old owner's final transfer completes in the release cycle.

## Timing
- Grant latency from IDLE: request at cycle N gives grant and first transfer at N+1.
- Handover latency: the old owner's last transfer is at cycle N; the new owner's first transfer is at N+1.
- Read: rdata = mem_rdata in the same cycle. The core samples it in the grant cycle, as in the single-cycle datapath.
- Write: memory captures at the rising edge that ends the grant cycle.
- Core with continuous c_req against a saturating loader: the core stalls at most MAX_BURST cycles between its own transfers.
- No combinational path from any req to any gnt. The only req-to-output paths are mem_we and core_stall.

## Test plan
- Reset, then c_req=1 alone at cycle 1 with c_we=1, c_addr=5, c_wdata=0xDEADBEEF:
  - Cycle 1: core_stall=1, mem_we=0.
  - Cycle 2: c_gnt=1, mem_we=1, mem_addr=5.
  - Read of word 5 afterwards returns 0xDEADBEEF.
- Both req high from IDLE immediately after reset:
  - OWN_C is granted first (last=1).
  - With both held, the pattern is 4 core transfers, 4 loader transfers, 4 core transfers, with no gap cycles.
- Loader holds l_req for 10 cycles, with l_we=1 and l_addr incrementing 0..9, while c_req=0:
  - l_gnt stays high for all 10 cycles and cnt stays 0.
  - Words 0..9 are written in order.
- Core drops c_req in cycle N while in OWN_C and l_req=1:
  - l_gnt=1 at N+1.
  - mem_we=0 at N.
- RST=1 in the 2nd cycle of a loader write burst:
  - mem_we=0 in that cycle.
  - Next cycle st=IDLE with all grants 0.
  - The word at the pending address is unchanged.
- Core load after the loader writes 0x00000013 at addr 3:
  - With c_we=0 and c_addr=3, rdata=0x00000013 in the c_gnt cycle.
  - core_stall=0 in that cycle.
